wave_dac_spi_12b: RTL
=====================

Name: wave_dac_spi_12b

Overview:
- Downstream consumer of the 12-bit waveform generator outputs (sine, cosine, triangle, square).
- Selects one waveform, applies a Q1.7 gain with saturation, and converts the result to offset-binary.
- Serialises each sample as a 16-bit SPI frame to a 12-bit single-channel DAC, at a fixed sample rate derived from `clock`.

Parameters:
- width, 12: sample width; the frame data field is exactly `width` bits.
- CLK_DIV, 4: `clock` cycles per SCLK half-period (>=1).
- SAMPLE_DIV, 256: `clock` cycles between sample ticks. Must be >= 2*CLK_DIV*16 + 2*CLK_DIV + 2; an elaboration-time check enforces this.
- CFG_BITS, 4'b0011: frame header (channel A, unbuffered, 1x, active).

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- sin_in  in  width  signed sine sample
- cos_in  in  width  signed cosine sample
- tri_in  in  width  signed triangle sample
- sqr_in  in  width  signed square sample
- wave_sel  in  2  0=sin, 1=cos, 2=tri, 3=sqr
- gain  in  8  unsigned Q1.7 (128 = 1.0)
- enable  in  1  1 = frames are emitted
- dac_cs_n  out  1  SPI chip select, active low
- dac_sclk  out  1  SPI clock, idle low
- dac_mosi  out  1  SPI data, MSB first
- busy  out  1  high while a frame is in flight
- sample_tick  out  1  one-cycle pulse at each sample instant

Behaviour:
- Reset values (asynchronous):
  - dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, sample_tick=0.
  - Tick counter=0, FSM=IDLE.
- Tick counter:
  - Free-runs 0..SAMPLE_DIV-1 and wraps to 0.
  - sample_tick=1 in the cycle the counter equals SAMPLE_DIV-1.
  - Runs regardless of `enable`.
- Datapath, registered in the cycle after sample_tick:
  - mux per wave_sel.
  - prod = sample * {1'b0,gain}: signed, width+9 bits.
  - scaled = prod >>> 7.
  - Saturate to [-2048, +2047].
  - code = scaled with MSB inverted (offset binary).
  - Frame = {CFG_BITS, code}.
- FSM:
  - IDLE: if sample_tick && enable, go to LOAD.
  - LOAD (1 cycle): latch frame; dac_cs_n<=0, dac_mosi<=frame[15], busy<=1.
  - SHIFT, 16 bits, each bit 2*CLK_DIV clocks:
    - dac_sclk rises after CLK_DIV clocks and falls after another CLK_DIV.
    - On each falling edge the next bit is presented on dac_mosi.
    - After the 16th falling edge, go to CS_HOLD.
  - CS_HOLD: dac_cs_n<=1; hold for CLK_DIV clocks; then IDLE with busy<=0 and dac_mosi<=0.
- Latency: sample_tick to dac_cs_n falling = 2 clocks. Frame length = 1 + 32*CLK_DIV + CLK_DIV clocks.
- Input sampling: inputs are sampled only in the cycle after sample_tick. Changes mid-frame do not affect the frame in flight.
- enable:
  - enable=0 in IDLE: no frame starts.
  - enable deasserted mid-frame: the current frame completes and no further frames start.
- A tick arriving while busy is ignored. The SAMPLE_DIV constraint makes this impossible, but the guard is required.
- gain=0 gives code 0x800. Saturation occurs for gain>128 with large inputs.
- Reset asserted mid-frame: dac_cs_n returns to 1 immediately (asynchronously) and the partial frame is discarded.

Optional Feature:
- Macro: `DAC_LDAC_EN`.
- When defined:
  - Adds output `dac_ldac_n` (1 bit, reset value 1).
  - After CS_HOLD, an extra LDAC state drives dac_ldac_n=0 for CLK_DIV clocks, then returns to IDLE; busy stays high through LDAC.
  - Frame length grows by CLK_DIV clocks.
- When undefined: the port and the LDAC state are absent; the DAC is assumed to update on the CS rising edge.

Decomposition:
- Shared package `wave_dac_pkg`:
  - waveform-select constants WAVE_SIN/COS/TRI/SQR.
  - FSM state encodings IDLE/LOAD/SHIFT/CS_HOLD/LDAC.
  - FRAME_W=16.
  - Q1.7 unity constant GAIN_ONE=128.
- One sub-module, `wave_scale_sat`: combinational mux, multiply, shift and saturation, plus MSB inversion. It is instantiated once; the FSM and counters stay in the top.

Test Plan:
- Sample 0, unity gain, CLK_DIV=4: wave_sel=0, sin_in=0, gain=128, enable=1 -> one frame per 256 clocks; MOSI bits 0x3800 MSB first; cs_n low for 129 clocks.
- Positive saturation: sqr_in=+2047, wave_sel=3, gain=255 -> code clamps to 0xFFF; frame 0x3FFF.
- Negative and half gain: tri_in=-2048, wave_sel=2, gain=64 -> scaled=-1024, code 0x400, frame 0x3400. A second run with gain=0 gives frame 0x3800.
- Enable gating: enable drops during bit 5 -> that frame completes all 16 bits, then cs_n stays high across the next 3 ticks; busy=0.
- Mid-frame reset: resetn asserted at bit 8 -> same cycle cs_n=1, sclk=0, busy=0. After release, the first frame begins 2 clocks after the first sample_tick, which comes 256 clocks after release.
- With `DAC_LDAC_EN`: ldac_n low for exactly 4 clocks, starting 4 clocks after the cs_n rise; busy stays high until ldac_n returns to 1.

Source files
------------

// File: rtl/wave_dac_pkg.sv
// wave_dac_pkg: shared constants and FSM encoding for the waveform-to-SPI DAC path.
package wave_dac_pkg;
  localparam logic [1:0] WAVE_SIN = 2'd0, WAVE_COS = 2'd1, WAVE_TRI = 2'd2, WAVE_SQR = 2'd3;
  localparam int FRAME_W = 16;
  localparam logic [7:0] GAIN_ONE = 8'd128;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CS_HOLD, LDAC} state_t;
endpackage

// File: rtl/wave_dac_spi_12b_scale.sv
// wave_scale_sat: selects a waveform, applies Q1.7 gain with saturation, emits offset-binary code.
module wave_scale_sat
  import wave_dac_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_sin,
  input  logic [W-1:0] i_cos,
  input  logic [W-1:0] i_tri,
  input  logic [W-1:0] i_sqr,
  input  logic [7:0]   i_gain,
  output logic [W-1:0] o_code
);
  localparam logic signed [W+8:0] P_MAX = (W+9)'((1 << (W-1)) - 1);
  localparam logic signed [W+8:0] P_MIN = ~P_MAX;
  logic [W-1:0] w_sample, w_sat;
  logic signed [W+8:0] w_prod, w_scaled;
  always_comb begin
    w_sample = i_sel == WAVE_SIN ? i_sin : i_sel == WAVE_COS ? i_cos : i_sel == WAVE_TRI ? i_tri : i_sqr;
    w_prod = (W+9)'($signed(w_sample)) * (W+9)'($signed({1'b0, i_gain}));
    w_scaled = w_prod >>> $clog2(GAIN_ONE);
    w_sat = w_scaled > P_MAX ? P_MAX[W-1:0] : w_scaled < P_MIN ? P_MIN[W-1:0] : w_scaled[W-1:0];
    o_code = {~w_sat[W-1], w_sat[W-2:0]};
  end
endmodule

// File: rtl/wave_dac_spi_12b.sv
// wave_dac_spi_12b: periodic sample tick, scaled waveform framed as 16-bit SPI to a 12-bit DAC.
// Optional `DAC_LDAC_EN adds a dac_ldac_n strobe after chip select is released.
module wave_dac_spi_12b
  import wave_dac_pkg::*;
#(
  parameter int         width      = 12,
  parameter int         CLK_DIV    = 4,
  parameter int         SAMPLE_DIV = 256,
  parameter logic [3:0] CFG_BITS   = 4'b0011
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [width-1:0] sin_in,
  input  logic [width-1:0] cos_in,
  input  logic [width-1:0] tri_in,
  input  logic [width-1:0] sqr_in,
  input  logic [1:0]       wave_sel,
  input  logic [7:0]       gain,
  input  logic             enable,
  output logic             dac_cs_n,
  output logic             dac_sclk,
  output logic             dac_mosi,
  output logic             busy,
  output logic             sample_tick
`ifdef DAC_LDAC_EN
  ,
  output logic             dac_ldac_n
`endif
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(FRAME_W);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL = CW'(2 * CLK_DIV - 1);

  if (SAMPLE_DIV < 2*CLK_DIV*FRAME_W + 2*CLK_DIV + 2 || CLK_DIV < 1 || width + 4 != FRAME_W) begin : g_bad_cfg
    $error("wave_dac_spi_12b: SAMPLE_DIV too small for one frame, or bad CLK_DIV/width");
  end

  logic [TW-1:0]      r_tick;
  state_t             r_state, w_state_nx;
  logic [CW-1:0]      r_cnt, w_cnt_nx;
  logic [BW-1:0]      r_bit, w_bit_nx;
  logic [FRAME_W-1:0] r_sh, w_sh_nx, w_frame;
  logic [width-1:0]   w_code;
  logic               r_cs_n, r_sclk, r_mosi, r_busy;
  logic               w_sclk_nx, w_mosi_nx, w_fall, w_half_end;

  wave_scale_sat #(.W(width)) u_scale (
    .i_sel (wave_sel),
    .i_sin (sin_in),
    .i_cos (cos_in),
    .i_tri (tri_in),
    .i_sqr (sqr_in),
    .i_gain(gain),
    .o_code(w_code)
  );

  assign sample_tick = r_tick == TW'(SAMPLE_DIV - 1);
  assign w_frame     = {CFG_BITS, w_code};
  assign w_fall      = r_cnt == FULL;
  assign w_half_end  = r_cnt == HALF;
  assign dac_cs_n    = r_cs_n;
  assign dac_sclk    = r_sclk;
  assign dac_mosi    = r_mosi;
  assign busy        = r_busy;

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_tick <= '0;
    else r_tick <= sample_tick ? '0 : r_tick + 1'b1;

  // Ticks are only honoured in IDLE, so a tick during a frame is dropped.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_sh_nx    = r_sh;
    w_sclk_nx  = 1'b0;
    w_mosi_nx  = 1'b0;
    case (r_state)
      IDLE: w_state_nx = sample_tick && enable ? LOAD : IDLE;
      LOAD: begin
        w_state_nx = SHIFT;
        w_sh_nx    = w_frame;
        w_mosi_nx  = w_frame[FRAME_W-1];
        w_cnt_nx   = '0;
        w_bit_nx   = '0;
      end
      SHIFT: begin
        w_cnt_nx   = w_fall ? '0 : r_cnt + 1'b1;
        w_sclk_nx  = r_cnt >= HALF && !w_fall;
        w_mosi_nx  = w_fall ? r_sh[FRAME_W-2] : r_mosi;
        w_sh_nx    = w_fall ? r_sh << 1 : r_sh;
        w_bit_nx   = w_fall ? r_bit + 1'b1 : r_bit;
        w_state_nx = w_fall && &r_bit ? CS_HOLD : SHIFT;
      end
      CS_HOLD: begin
        w_cnt_nx = w_half_end ? '0 : r_cnt + 1'b1;
`ifdef DAC_LDAC_EN
        w_state_nx = w_half_end ? LDAC : CS_HOLD;
`else
        w_state_nx = w_half_end ? IDLE : CS_HOLD;
`endif
      end
`ifdef DAC_LDAC_EN
      LDAC: begin
        w_cnt_nx   = w_half_end ? '0 : r_cnt + 1'b1;
        w_state_nx = w_half_end ? IDLE : LDAC;
      end
`endif
      default: w_state_nx = IDLE;
    endcase
  end

  // Strobes are registered from the current state, so each lags its state by one clock.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_sh    <= w_sh_nx;
      r_sclk  <= w_sclk_nx;
      r_mosi  <= w_mosi_nx;
      r_cs_n  <= !(r_state == LOAD || r_state == SHIFT);
      r_busy  <= r_state != IDLE;
    end

`ifdef DAC_LDAC_EN
  logic r_ldac_n;
  assign dac_ldac_n = r_ldac_n;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_ldac_n <= 1'b1;
    else r_ldac_n <= r_state != LDAC;
`endif
endmodule
